// File: rtl/audio_track_scheduler.sv
// audio_track_scheduler
//   Shares one sample memory and one PWM sample input between a looping
//   background-music track and N_REQ one-shot sound effects (index 0 has the
//   highest priority). Each track is read at its own sample rate. One sample
//   byte is presented per tick.
//
//   Ports
//     clk, rst_n          clock and synchronous active-low reset
//     music_en            background track plays whenever no SFX is granted
//     music_base/len/div  music track address, length (samples), clk per sample
//     sfx_req             one-cycle start pulse per requester
//     sfx_base/len/div    flat per-requester slices, snapshotted on request
//     mem_rd, mem_addr    read strobe and address to the sample memory
//     mem_data            read data, valid the cycle after mem_rd
//     sample_out          current sample, held between ticks
//     sample_vld          one-cycle pulse when sample_out updates
//     sfx_done            one-cycle pulse when SFX i publishes its last sample
//     active_src          0 = idle, 1 = music, 2+i = SFX i
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_IDLE  | nothing playing; no reads issued
//   ST_MUSIC | background track playing from its saved position
//   ST_SFX   | sound effect cur_q playing from offset 0
module audio_track_scheduler #(
   parameter int N_REQ  = 4,
   parameter int ADDR_W = 16,
   parameter int DATA_W = 8,
   parameter int DIV_W  = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    music_en,
   input  logic [ADDR_W-1:0]       music_base,
   input  logic [ADDR_W-1:0]       music_len,
   input  logic [DIV_W-1:0]        music_div,
   input  logic [N_REQ-1:0]        sfx_req,
   input  logic [N_REQ*ADDR_W-1:0] sfx_base,
   input  logic [N_REQ*ADDR_W-1:0] sfx_len,
   input  logic [N_REQ*DIV_W-1:0]  sfx_div,
   output logic                    mem_rd,
   output logic [ADDR_W-1:0]       mem_addr,
   input  logic [DATA_W-1:0]       mem_data,
   output logic [DATA_W-1:0]       sample_out,
   output logic                    sample_vld,
   output logic [N_REQ-1:0]        sfx_done,
   output logic [2:0]              active_src
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_MUSIC = 2'd1,
      ST_SFX   = 2'd2
   } state_t;

   function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
      return (d < DIV_W'(2)) ? DIV_W'(2) : d;
   endfunction

   state_t              state_q,    state_d;
   logic [IDX_W-1:0]    cur_q,      cur_d;
   logic [DIV_W-1:0]    cnt_q,      cnt_d;
   logic [ADDR_W-1:0]   off_q,      off_d;
   logic [ADDR_W-1:0]   mpos_q,     mpos_d;
   logic [ADDR_W-1:0]   act_base_q, act_base_d;
   logic [ADDR_W-1:0]   act_len_q,  act_len_d;
   logic [DIV_W-1:0]    act_div_q,  act_div_d;
   logic [N_REQ-1:0]    pend_q,     pend_d;
   logic [ADDR_W-1:0]   snap_base_q [N_REQ];
   logic [ADDR_W-1:0]   snap_base_d [N_REQ];
   logic [ADDR_W-1:0]   snap_len_q  [N_REQ];
   logic [ADDR_W-1:0]   snap_len_d  [N_REQ];
   logic [DIV_W-1:0]    snap_div_q  [N_REQ];
   logic [DIV_W-1:0]    snap_div_d  [N_REQ];
   logic                rd_q,       rd_d;
   logic                last_q,     last_d;
   logic [IDX_W-1:0]    last_idx_q, last_idx_d;
   logic [DATA_W-1:0]   sample_q,   sample_d;
   logic                vld_q,      vld_d;
   logic [N_REQ-1:0]    done_q,     done_d;
   logic [2:0]          src_q,      src_d;

   logic                tick;
   logic                any_pend;
   logic [IDX_W-1:0]    hp_idx;
   logic [ADDR_W-1:0]   play_off;
   logic                go_sfx, go_music, go_idle, enter;

   assign tick     = (state_q != ST_IDLE) && (cnt_q == act_div_q - DIV_W'(1));
   assign play_off = (state_q == ST_MUSIC) ? mpos_q : off_q;
   assign mem_rd   = tick;
   assign mem_addr = tick ? (act_base_q + play_off) : '0;

   always_comb begin
      any_pend = 1'b0;
      hp_idx   = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (pend_q[i]) begin
            any_pend = 1'b1;
            hp_idx   = IDX_W'(i);
         end
      end
   end

   always_comb begin
      go_sfx   = 1'b0;
      go_music = 1'b0;
      go_idle  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (any_pend)      go_sfx   = 1'b1;
            else if (music_en) go_music = 1'b1;
         end
         ST_MUSIC: begin
            if (any_pend)       go_sfx  = 1'b1;
            else if (!music_en) go_idle = 1'b1;
         end
         ST_SFX: begin
            // last_q marks the cycle the final sample is being published
            if (last_q) begin
               if (any_pend)      go_sfx   = 1'b1;
               else if (music_en) go_music = 1'b1;
               else               go_idle  = 1'b1;
            end else if (any_pend && (hp_idx <= cur_q)) begin
               // equal index means a re-request: restart from offset 0
               go_sfx = 1'b1;
            end
         end
         default: go_idle = 1'b1;
      endcase
      enter = go_sfx | go_music | go_idle;
   end

   always_comb begin
      state_d     = state_q;
      cur_d       = cur_q;
      cnt_d       = cnt_q;
      off_d       = off_q;
      mpos_d      = mpos_q;
      act_base_d  = act_base_q;
      act_len_d   = act_len_q;
      act_div_d   = act_div_q;
      pend_d      = pend_q;
      snap_base_d = snap_base_q;
      snap_len_d  = snap_len_q;
      snap_div_d  = snap_div_q;
      rd_d        = tick;
      last_idx_d  = cur_q;
      sample_d    = sample_q;
      vld_d       = 1'b0;
      done_d      = '0;
      src_d       = src_q;

      // A read in flight is published even if the track has changed since.
      if (rd_q) begin
         sample_d = mem_data;
         vld_d    = 1'b1;
      end
      if (last_q) done_d[last_idx_q] = 1'b1;

      last_d = tick && (state_q == ST_SFX) && !enter &&
               (off_q == act_len_q - ADDR_W'(1));

      // Music position advances on its own tick even if music is being left,
      // so resuming starts at the first sample not yet read.
      if ((state_q == ST_MUSIC) && tick) begin
         if (({1'b0, mpos_q} + (ADDR_W+1)'(1)) >= {1'b0, act_len_q}) mpos_d = '0;
         else                                                        mpos_d = mpos_q + ADDR_W'(1);
      end

      if (enter) begin
         cnt_d = '0;
         if (go_sfx) begin
            state_d         = ST_SFX;
            cur_d           = hp_idx;
            off_d           = '0;
            act_base_d      = snap_base_q[hp_idx];
            act_len_d       = snap_len_q[hp_idx];
            act_div_d       = snap_div_q[hp_idx];
            pend_d[hp_idx]  = 1'b0;
         end else if (go_music) begin
            state_d    = ST_MUSIC;
            act_base_d = music_base;
            act_len_d  = music_len;
            act_div_d  = clamp_div(music_div);
            if (mpos_q >= music_len) mpos_d = '0;
         end else begin
            state_d = ST_IDLE;
         end
      end else if (state_q != ST_IDLE) begin
         if (tick) begin
            cnt_d = '0;
            if (state_q == ST_SFX) off_d = off_q + ADDR_W'(1);
         end else begin
            cnt_d = cnt_q + DIV_W'(1);
         end
      end

      // Latching after the grant clear keeps a same-cycle request pending.
      for (int i = 0; i < N_REQ; i++) begin
         if (sfx_req[i] && (sfx_len[i*ADDR_W +: ADDR_W] != '0)) begin
            pend_d[i]      = 1'b1;
            snap_base_d[i] = sfx_base[i*ADDR_W +: ADDR_W];
            snap_len_d[i]  = sfx_len[i*ADDR_W +: ADDR_W];
            snap_div_d[i]  = clamp_div(sfx_div[i*DIV_W +: DIV_W]);
         end
      end

      case (state_d)
         ST_MUSIC: src_d = 3'd1;
         ST_SFX:   src_d = 3'(cur_d) + 3'd2;
         default:  src_d = 3'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cur_q       <= '0;
         cnt_q       <= '0;
         off_q       <= '0;
         mpos_q      <= '0;
         act_base_q  <= '0;
         act_len_q   <= '0;
         act_div_q   <= DIV_W'(2);
         pend_q      <= '0;
         snap_base_q <= '{default: '0};
         snap_len_q  <= '{default: '0};
         snap_div_q  <= '{default: '0};
         rd_q        <= 1'b0;
         last_q      <= 1'b0;
         last_idx_q  <= '0;
         sample_q    <= '0;
         vld_q       <= 1'b0;
         done_q      <= '0;
         src_q       <= '0;
      end else begin
         state_q     <= state_d;
         cur_q       <= cur_d;
         cnt_q       <= cnt_d;
         off_q       <= off_d;
         mpos_q      <= mpos_d;
         act_base_q  <= act_base_d;
         act_len_q   <= act_len_d;
         act_div_q   <= act_div_d;
         pend_q      <= pend_d;
         snap_base_q <= snap_base_d;
         snap_len_q  <= snap_len_d;
         snap_div_q  <= snap_div_d;
         rd_q        <= rd_d;
         last_q      <= last_d;
         last_idx_q  <= last_idx_d;
         sample_q    <= sample_d;
         vld_q       <= vld_d;
         done_q      <= done_d;
         src_q       <= src_d;
      end
   end

   assign sample_out = sample_q;
   assign sample_vld = vld_q;
   assign sfx_done   = done_q;
   assign active_src = src_q;

endmodule

// File: tb/tb_audio_track_scheduler.sv
// Bench for audio_track_scheduler: directed scenarios followed by random
// requests, every cycle compared against a track-level reference model.
module tb_audio_track_scheduler;

   localparam int N = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         music_en;
   logic [15:0]  music_base, music_len;
   logic [31:0]  music_div;
   logic [3:0]   sfx_req;
   logic [63:0]  sfx_base, sfx_len;
   logic [127:0] sfx_div;
   logic         mem_rd;
   logic [15:0]  mem_addr;
   logic [7:0]   mem_data = 8'h00;
   logic [7:0]   sample_out;
   logic         sample_vld;
   logic [3:0]   sfx_done;
   logic [2:0]   active_src;

   int vecs = 0;
   int errs = 0;

   always #5 clk = ~clk;

   audio_track_scheduler dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .music_en   (music_en),
      .music_base (music_base),
      .music_len  (music_len),
      .music_div  (music_div),
      .sfx_req    (sfx_req),
      .sfx_base   (sfx_base),
      .sfx_len    (sfx_len),
      .sfx_div    (sfx_div),
      .mem_rd     (mem_rd),
      .mem_addr   (mem_addr),
      .mem_data   (mem_data),
      .sample_out (sample_out),
      .sample_vld (sample_vld),
      .sfx_done   (sfx_done),
      .active_src (active_src)
   );

   function automatic logic [7:0] mem_fn(input logic [15:0] a);
      return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'hA5;
   endfunction

   // sample memory: synchronous read, one cycle latency
   always @(posedge clk) if (mem_rd) mem_data <= mem_fn(mem_addr);

   // reference model: source (0 idle, 1 music, 2+i sfx), cycles left before
   // the next read, play offsets, pending snapshots, read/finish in flight
   int   m_src, m_rem, m_off, m_mpos, m_ab, m_al, m_ad, m_fly, m_fin;
   bit   m_pend [N];
   int   m_pb [N];
   int   m_pl [N];
   int   m_pd [N];
   logic       e_vld;
   logic [7:0] e_out;
   logic [3:0] e_done;

   task automatic model_reset();
      m_src = 0; m_rem = 1; m_off = 0; m_mpos = 0;
      m_ab = 0; m_al = 0; m_ad = 2; m_fly = -1; m_fin = -1;
      for (int i = 0; i < N; i++) begin
         m_pend[i] = 0; m_pb[i] = 0; m_pl[i] = 0; m_pd[i] = 2;
      end
      e_vld = 1'b0; e_out = 8'h00; e_done = 4'h0;
   endtask

   task automatic step();
      logic        e_rd;
      logic [15:0] e_addr;
      logic        n_vld;
      logic [7:0]  n_out;
      logic [3:0]  n_done;
      int          hp, tgt, k;
      bit          enter;

      e_rd   = (m_src != 0) && (m_rem == 0);
      e_addr = e_rd ? 16'(m_ab + ((m_src == 1) ? m_mpos : m_off)) : 16'h0000;

      vecs++;
      assert (mem_rd === e_rd) else begin
         errs++; $error("FAIL mem_rd: observed %0b expected %0b", mem_rd, e_rd);
      end
      vecs++;
      assert (mem_addr === e_addr) else begin
         errs++; $error("FAIL mem_addr: observed %0h expected %0h", mem_addr, e_addr);
      end
      vecs++;
      assert (sample_vld === e_vld) else begin
         errs++; $error("FAIL sample_vld: observed %0b expected %0b", sample_vld, e_vld);
      end
      vecs++;
      assert (sample_out === e_out) else begin
         errs++; $error("FAIL sample_out: observed %0h expected %0h", sample_out, e_out);
      end
      vecs++;
      assert (sfx_done === e_done) else begin
         errs++; $error("FAIL sfx_done: observed %0b expected %0b", sfx_done, e_done);
      end
      vecs++;
      assert (active_src === 3'(m_src)) else begin
         errs++; $error("FAIL active_src: observed %0d expected %0d", active_src, m_src);
      end

      if (!rst_n) begin
         model_reset();
      end else begin
         n_vld  = (m_fly >= 0);
         n_out  = n_vld ? mem_fn(16'(m_fly)) : e_out;
         n_done = (m_fin >= 0) ? 4'(1 << m_fin) : 4'h0;

         hp = -1;
         for (int i = N - 1; i >= 0; i--) if (m_pend[i]) hp = i;

         tgt = m_src; enter = 0;
         if (m_src < 2 || m_fin >= 0) begin
            tgt   = (hp >= 0) ? hp + 2 : (music_en ? 1 : 0);
            enter = (tgt != m_src) || (m_fin >= 0);
         end else if (hp >= 0 && hp <= m_src - 2) begin
            tgt = hp + 2; enter = 1;
         end

         m_fin = (e_rd && m_src >= 2 && m_off == m_al - 1 && !enter) ? m_src - 2 : -1;
         m_fly = e_rd ? int'(e_addr) : -1;
         if (m_src == 1 && e_rd) m_mpos = (m_mpos + 1 >= m_al) ? 0 : m_mpos + 1;

         if (enter) begin
            if (tgt >= 2) begin
               k = tgt - 2;
               m_ab = m_pb[k]; m_al = m_pl[k]; m_ad = m_pd[k]; m_off = 0; m_pend[k] = 0;
            end else if (tgt == 1) begin
               m_ab = int'(music_base); m_al = int'(music_len);
               m_ad = (music_div < 32'd2) ? 2 : int'(music_div);
               if (m_mpos >= m_al) m_mpos = 0;
            end
            m_rem = m_ad - 1;
            m_src = tgt;
         end else if (m_src != 0) begin
            if (e_rd) begin
               m_rem = m_ad - 1;
               if (m_src >= 2) m_off++;
            end else begin
               m_rem--;
            end
         end

         for (int i = 0; i < N; i++) begin
            if (sfx_req[i] && sfx_len[i*16 +: 16] != 16'h0) begin
               m_pend[i] = 1;
               m_pb[i] = int'(sfx_base[i*16 +: 16]);
               m_pl[i] = int'(sfx_len[i*16 +: 16]);
               m_pd[i] = (sfx_div[i*32 +: 32] < 32'd2) ? 2 : int'(sfx_div[i*32 +: 32]);
            end
         end

         e_vld = n_vld; e_out = n_out; e_done = n_done;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic run(input int n);
      for (int c = 0; c < n; c++) step();
   endtask

   task automatic pulse(input logic [3:0] mask);
      sfx_req = mask;
      step();
      sfx_req = 4'h0;
   endtask

   task automatic set_sfx(input int i, input logic [15:0] b, input logic [15:0] l,
                          input logic [31:0] d);
      sfx_base[i*16 +: 16] = b;
      sfx_len[i*16 +: 16]  = l;
      sfx_div[i*32 +: 32]  = d;
   endtask

   initial begin
      rst_n = 1'b0; music_en = 1'b0;
      music_base = 16'h0; music_len = 16'h0; music_div = 32'h0;
      sfx_req = 4'h0; sfx_base = '0; sfx_len = '0; sfx_div = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      model_reset();
      step();
      rst_n = 1'b1;

      // looping music, base 0x100, 3 samples, 4 clk per sample
      music_base = 16'h0100; music_len = 16'd3; music_div = 32'd4; music_en = 1'b1;
      run(20);

      // single SFX 2 from idle
      music_en = 1'b0;
      run(3);
      set_sfx(2, 16'h0040, 16'd2, 32'd5);
      pulse(4'b0100);
      run(20);

      // SFX 3 preempted by SFX 1
      set_sfx(3, 16'h0300, 16'd8, 32'd3);
      pulse(4'b1000);
      run(6);
      set_sfx(1, 16'h0500, 16'd2, 32'd3);
      pulse(4'b0010);
      run(15);

      // music interrupted by a one-sample SFX 0, then resumes
      music_base = 16'h0200; music_len = 16'd10; music_div = 32'd2; music_en = 1'b1;
      run(12);
      set_sfx(0, 16'h0080, 16'd1, 32'd3);
      pulse(4'b0001);
      run(20);

      // simultaneous requests, then a zero-length request
      music_en = 1'b0;
      run(4);
      set_sfx(0, 16'h0010, 16'd2, 32'd2);
      set_sfx(1, 16'h0020, 16'd2, 32'd2);
      pulse(4'b0011);
      run(20);
      set_sfx(2, 16'h0030, 16'd0, 32'd2);
      pulse(4'b0100);
      run(8);

      // divisors below 2 and address wrap
      set_sfx(1, 16'hFFFF, 16'd2, 32'd0);
      pulse(4'b0010);
      run(10);
      set_sfx(2, 16'h0007, 16'd2, 32'd1);
      pulse(4'b0100);
      run(8);

      // reset in the middle of an SFX
      set_sfx(3, 16'h0600, 16'd6, 32'd4);
      pulse(4'b1000);
      run(7);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      run(8);

      // re-request of the playing SFX restarts it
      set_sfx(2, 16'h0090, 16'd3, 32'd3);
      pulse(4'b0100);
      run(5);
      pulse(4'b0100);
      run(15);

      // random traffic
      for (int c = 0; c < 3000; c++) begin
         sfx_req = ($urandom_range(0, 11) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
         if (sfx_req != 4'h0) begin
            for (int i = 0; i < N; i++)
               set_sfx(i, 16'($urandom), 16'($urandom_range(0, 4)), 32'($urandom_range(0, 5)));
         end
         if ($urandom_range(0, 63) == 0) music_en = ~music_en;
         if ($urandom_range(0, 99) == 0) begin
            music_base = 16'($urandom);
            music_len  = 16'($urandom_range(0, 6));
            music_div  = 32'($urandom_range(0, 4));
         end
         rst_n = ($urandom_range(0, 499) != 0);
         step();
      end
      sfx_req = 4'h0;
      rst_n   = 1'b1;
      run(4);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
